mem_bus_arbiter: RTL and testbench

- Shares one 32-bit memory bus port between two requesters: the IF stage (instruction fetch) and the MEM stage (load/store).
- Allows one outstanding transaction at a time.
- Fixed priority goes to MEM; a starvation counter forces an IF grant after STARVE_MAX consecutive MEM wins.
- Sits between rv32core's fetch/memory stages and the unified memory; the pipeline stalls on a stage whose request is not yet granted or answered.

---
 rtl/mem_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_bus_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter (IF fetch, MEM load/store) sharing one 32-bit memory bus.
// One outstanding transaction; MEM has priority with a starvation escape for IF.
module mem_bus_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_be_i,
  output logic        mem_gnt_o,
  output logic        mem_rvalid_o,
  output logic [31:0] mem_rdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  output logic        arb_busy_o
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e      state_q;
  logic        owner_q;   // 1 = MEM owns the bus, 0 = IF
  logic [3:0]  starve_q;
  logic [3:0]  starve_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic        if_win;
  logic        mem_win;

  always_comb begin
    if_win  = 1'b0;
    mem_win = 1'b0;
    if (state_q == IDLE) begin
      if (if_req_i && (!mem_req_i || starve_q == STARVE_LIM)) begin
        if_win = 1'b1;
      end else if (mem_req_i) begin
        mem_win = 1'b1;
      end
    end
  end

  // Count only MEM wins that actually kept a waiting IF out.
  always_comb begin
    starve_d = starve_q;
    if (if_win) begin
      starve_d = 4'd0;
    end else if (mem_win) begin
      if (!if_req_i) begin
        starve_d = 4'd0;
      end else if (starve_q != STARVE_LIM) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      starve_q <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      we_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (if_win || mem_win) begin
            owner_q  <= mem_win;
            addr_q   <= mem_win ? mem_addr_i : if_addr_i;
            we_q     <= mem_win & mem_we_i;
            wdata_q  <= mem_win ? mem_wdata_i : 32'd0;
            be_q     <= mem_win ? mem_be_i : 4'hF;
            starve_q <= starve_d;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (bus_gnt_i) state_q <= WAIT;
        end
        WAIT: begin
          if (bus_rvalid_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Grants are combinational but must stay low while reset is held.
  assign if_gnt_o     = rst_n & if_win;
  assign mem_gnt_o    = rst_n & mem_win;

  assign if_rvalid_o  = (state_q == WAIT) && !owner_q && bus_rvalid_i;
  assign mem_rvalid_o = (state_q == WAIT) &&  owner_q && bus_rvalid_i;
  assign if_rdata_o   = rst_n ? bus_rdata_i : 32'd0;
  assign mem_rdata_o  = rst_n ? bus_rdata_i : 32'd0;

  assign bus_req_o    = (state_q == REQ);
  assign bus_we_o     = we_q;
  assign bus_addr_o   = addr_q;
  assign bus_wdata_o  = wdata_q;
  assign bus_be_o     = be_q;
  assign arb_busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: inputs change on the falling edge,
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        mem_req_i, mem_we_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [3:0]  mem_be_i;
  logic        mem_gnt_o, mem_rvalid_o;
  logic [31:0] mem_rdata_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i, bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        arb_busy_o;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_be_i(mem_be_i), .mem_gnt_o(mem_gnt_o),
    .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_gnt_i(bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i),
    .arb_busy_o(arb_busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic fall();
    @(negedge clk);
  endtask

  logic [1:0] exp_order [6];
  logic [1:0] got;

  initial begin
    rst_n = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h0;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0;
    mem_wdata_i = 32'h0; mem_be_i = 4'h0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = 32'h0;

    // Reset state, with both requests raised to prove grants are forced low
    fall(); #1;
    chk("rst if_gnt", if_gnt_o, 0);
    chk("rst mem_gnt", mem_gnt_o, 0);
    chk("rst bus_req", bus_req_o, 0);
    chk("rst busy", arb_busy_o, 0);
    chk("rst bus_be", bus_be_o, 0);
    chk("rst bus_addr", bus_addr_o, 0);
    chk("rst rvalids", {if_rvalid_o, mem_rvalid_o}, 0);
    fall();
    if_req_i = 1'b0; mem_req_i = 1'b0; rst_n = 1'b1;

    // IF-only fetch with immediate bus accept
    fall();
    if_req_i = 1'b1; if_addr_i = 32'h100; bus_gnt_i = 1'b1; #1;
    chk("t1 if_gnt", if_gnt_o, 1);
    chk("t1 mem_gnt", mem_gnt_o, 0);
    fall();
    if_req_i = 1'b0; #1;
    chk("t1 bus_req", bus_req_o, 1);
    chk("t1 bus_addr", bus_addr_o, 32'h100);
    chk("t1 bus_be", bus_be_o, 4'hF);
    chk("t1 bus_we", bus_we_o, 0);
    chk("t1 if_gnt pulse", if_gnt_o, 0);
    fall();
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h00500093; #1;
    chk("t1 if_rvalid", if_rvalid_o, 1);
    chk("t1 if_rdata", if_rdata_o, 32'h00500093);
    chk("t1 mem_rvalid", mem_rvalid_o, 0);
    chk("t1 bus_req wait", bus_req_o, 0);
    fall();
    bus_rvalid_i = 1'b0; #1;
    chk("t1 idle busy", arb_busy_o, 0);

    // Contested: MEM store first, then IF
    if_req_i = 1'b1; if_addr_i = 32'h200;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h2000;
    mem_wdata_i = 32'hDEADBEEF; mem_be_i = 4'b0011; bus_gnt_i = 1'b1; #1;
    chk("t2 mem_gnt", mem_gnt_o, 1);
    chk("t2 if_gnt", if_gnt_o, 0);
    fall();
    mem_req_i = 1'b0; mem_we_i = 1'b0; #1;
    chk("t2 bus_we", bus_we_o, 1);
    chk("t2 bus_addr", bus_addr_o, 32'h2000);
    chk("t2 bus_be", bus_be_o, 4'b0011);
    chk("t2 bus_wdata", bus_wdata_o, 32'hDEADBEEF);
    fall();
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0; #1;
    chk("t2 mem_rvalid", mem_rvalid_o, 1);
    chk("t2 if_rvalid", if_rvalid_o, 0);
    fall();
    bus_rvalid_i = 1'b0; #1;
    chk("t2 if_gnt after", if_gnt_o, 1);
    fall();
    if_req_i = 1'b0; #1;
    chk("t2 if bus_addr", bus_addr_o, 32'h200);
    chk("t2 if bus_we", bus_we_o, 0);
    chk("t2 if bus_wdata", bus_wdata_o, 0);
    fall();
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h12345678; #1;
    chk("t2 if_rvalid", if_rvalid_o, 1);
    chk("t2 if_rdata", if_rdata_o, 32'h12345678);
    fall();
    bus_rvalid_i = 1'b0;

    // Starvation: both held, expect MEM x4, IF, MEM (2'b10 = MEM, 2'b01 = IF)
    exp_order[0] = 2'b10; exp_order[1] = 2'b10; exp_order[2] = 2'b10;
    exp_order[3] = 2'b10; exp_order[4] = 2'b01; exp_order[5] = 2'b10;
    if_req_i = 1'b1; mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h3000;
    mem_be_i = 4'hF; bus_gnt_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      got = {mem_gnt_o, if_gnt_o};
      chk($sformatf("t3 grant %0d", k), got, exp_order[k]);
      fall();
      fall();
      bus_rvalid_i = 1'b1;
      fall();
      bus_rvalid_i = 1'b0;
    end
    if_req_i = 1'b0; mem_req_i = 1'b0;
    fall();

    // Backpressure: MEM read, bus_gnt_i low for 5 cycles, stray rvalid in REQ
    mem_req_i = 1'b1; mem_addr_i = 32'h4000; mem_be_i = 4'b1100; bus_gnt_i = 1'b0; #1;
    chk("t4 mem_gnt", mem_gnt_o, 1);
    fall();
    if_req_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus_rvalid_i = (c == 2);
      #1;
      chk($sformatf("t4 bus_req c%0d", c), bus_req_o, 1);
      chk($sformatf("t4 fields c%0d", c), {bus_addr_o[27:0], bus_be_o}, {28'h0004000, 4'b1100});
      chk($sformatf("t4 gnts c%0d", c), {if_gnt_o, mem_gnt_o}, 0);
      chk($sformatf("t4 rvalids c%0d", c), {if_rvalid_o, mem_rvalid_o}, 0);
      chk($sformatf("t4 busy c%0d", c), arb_busy_o, 1);
      fall();
    end
    bus_rvalid_i = 1'b0; bus_gnt_i = 1'b1; #1;
    chk("t4 still req", bus_req_o, 1);
    fall();
    bus_gnt_i = 1'b0; if_req_i = 1'b0; mem_req_i = 1'b0;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'hCAFEF00D; #1;
    chk("t4 mem_rvalid", mem_rvalid_o, 1);
    chk("t4 mem_rdata", mem_rdata_o, 32'hCAFEF00D);
    fall();

    // Stray rvalid in IDLE
    bus_rvalid_i = 1'b1; #1;
    chk("t5 idle rvalids", {if_rvalid_o, mem_rvalid_o}, 0);
    chk("t5 idle busy", arb_busy_o, 0);
    fall();
    bus_rvalid_i = 1'b0; #1;
    chk("t5 still idle", {arb_busy_o, bus_req_o}, 0);

    // Reset during WAIT with MEM owner, then a late response
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h5000; mem_wdata_i = 32'hA5A5A5A5;
    mem_be_i = 4'hF; bus_gnt_i = 1'b1;
    fall();
    mem_req_i = 1'b0;
    fall();
    bus_gnt_i = 1'b0; #1;
    chk("t6 in wait", {arb_busy_o, bus_req_o}, 2'b10);
    mem_req_i = 1'b1; bus_rdata_i = 32'h77777777; rst_n = 1'b0; #1;
    chk("t6 rst busy", arb_busy_o, 0);
    chk("t6 rst mem_gnt", mem_gnt_o, 0);
    chk("t6 rst bus", {bus_req_o, bus_we_o, bus_be_o}, 0);
    chk("t6 rst bus_addr", bus_addr_o, 0);
    chk("t6 rst bus_wdata", bus_wdata_o, 0);
    chk("t6 rst rdata", mem_rdata_o, 0);
    fall();
    mem_req_i = 1'b0; rst_n = 1'b1; bus_rvalid_i = 1'b1; #1;
    chk("t6 late rvalid", {if_rvalid_o, mem_rvalid_o}, 0);
    chk("t6 idle", arb_busy_o, 0);
    fall();
    bus_rvalid_i = 1'b0; #1;
    chk("t6 idle after", {arb_busy_o, bus_req_o}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
